// File: rtl/decode_stage.sv
// Decode / register-read stage: registers {OP,A,B,C} for execute, stalls on RAW hazards.
// Optional HAZARD_CNT_EN adds a saturating STALL_CNT output.
module decode_stage #(
    parameter int          DEPTH  = 3,
    parameter logic [7:0]  NOP_OP = 8'h00
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    input  logic [31:0] IN_INSTR,
    output logic        IN_READY,
    output logic [15:0] A_no,
    output logic [15:0] B_no,
    input  logic [15:0] AS,
    input  logic [15:0] BS,
    output logic        OUT_VALID,
    output logic [7:0]  OUT_OP,
    output logic [15:0] OUT_A,
    output logic [15:0] OUT_B,
    output logic [15:0] OUT_C
`ifdef HAZARD_CNT_EN
    ,
    output logic [15:0] STALL_CNT
`endif
);

    logic [7:0] op;
    logic [7:0] fld_a;
    logic [7:0] fld_b;
    logic [7:0] fld_c;
    logic       reads_b;
    logic       reads_c;
    logic       writes_a;
    logic       hit;
    logic       stall;
    logic       issued;

    logic       sb_v    [DEPTH];
    logic [7:0] sb_dest [DEPTH];

    assign op    = IN_INSTR[31:24];
    assign fld_a = IN_INSTR[23:16];
    assign fld_b = IN_INSTR[15:8];
    assign fld_c = IN_INSTR[7:0];

    assign A_no = {8'h00, fld_b};
    assign B_no = {8'h00, fld_c};

    always_comb begin
        reads_b  = 1'b0;
        reads_c  = 1'b0;
        writes_a = 1'b0;
        case (op)
            8'h01, 8'h02, 8'h03, 8'h04: begin
                reads_b  = 1'b1;
                reads_c  = 1'b1;
                writes_a = 1'b1;
            end
            8'h05: begin
                reads_b  = 1'b1;
                writes_a = 1'b1;
            end
            8'h06, 8'h07: writes_a = 1'b1;
            8'h08:        reads_b  = 1'b1;
            default: ;
        endcase
    end

    // The bank has no write-through, so every in-flight writer blocks, including the one in WB.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sb_v[i] && ((reads_b && (sb_dest[i] == fld_b)) ||
                            (reads_c && (sb_dest[i] == fld_c))))
                hit = 1'b1;
        end
    end

    assign stall    = IN_VALID & hit;
    assign IN_READY = ~stall;
    assign issued   = IN_VALID & ~stall;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                sb_v[i]    <= 1'b0;
                sb_dest[i] <= 8'h00;
            end
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                sb_v[i]    <= sb_v[i-1];
                sb_dest[i] <= sb_dest[i-1];
            end
            sb_v[0]    <= issued & writes_a;
            sb_dest[0] <= fld_a;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            OUT_VALID <= 1'b0;
            OUT_OP    <= NOP_OP;
            OUT_A     <= 16'h0000;
            OUT_B     <= 16'h0000;
            OUT_C     <= 16'h0000;
        end else if (issued) begin
            OUT_VALID <= 1'b1;
            OUT_OP    <= op;
            OUT_A     <= {8'h00, fld_a};
            OUT_B     <= reads_b ? AS : {8'h00, fld_b};
            OUT_C     <= reads_c ? BS : {8'h00, fld_c};
        end else begin
            OUT_VALID <= 1'b0;
            OUT_OP    <= NOP_OP;
            OUT_A     <= 16'h0000;
            OUT_B     <= 16'h0000;
            OUT_C     <= 16'h0000;
        end
    end

`ifdef HAZARD_CNT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            STALL_CNT <= 16'h0000;
        else if (stall && (STALL_CNT != 16'hFFFF))
            STALL_CNT <= STALL_CNT + 16'h0001;
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// against a model that tracks, per register, the cycle its latest writer issued.
module tb_decode_stage;

    localparam int         DEPTH  = 3;
    localparam logic [7:0] NOP_OP = 8'h00;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic [31:0] IN_INSTR;
    logic        IN_READY;
    logic [15:0] A_no;
    logic [15:0] B_no;
    logic [15:0] AS;
    logic [15:0] BS;
    logic        OUT_VALID;
    logic [7:0]  OUT_OP;
    logic [15:0] OUT_A;
    logic [15:0] OUT_B;
    logic [15:0] OUT_C;
`ifdef HAZARD_CNT_EN
    logic [15:0] STALL_CNT;
`endif

    logic [15:0] bank [256];
    int          last_cyc [256];
    int          cyc;
    int          stall_cnt_model;
    int          assert_count;
    int          fail_count;
    logic        ready_seen;

    decode_stage #(.DEPTH(DEPTH), .NOP_OP(NOP_OP)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_INSTR  (IN_INSTR),
        .IN_READY  (IN_READY),
        .A_no      (A_no),
        .B_no      (B_no),
        .AS        (AS),
        .BS        (BS),
        .OUT_VALID (OUT_VALID),
        .OUT_OP    (OUT_OP),
        .OUT_A     (OUT_A),
        .OUT_B     (OUT_B),
        .OUT_C     (OUT_C)
`ifdef HAZARD_CNT_EN
        ,
        .STALL_CNT (STALL_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    // Register bank stand-in: combinational reads of the addresses decode drives.
    assign AS = bank[A_no[7:0]];
    assign BS = bank[B_no[7:0]];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic op_reads_b(input logic [7:0] o);
        return o inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h08};
    endfunction

    function automatic logic op_reads_c(input logic [7:0] o);
        return o inside {8'h01, 8'h02, 8'h03, 8'h04};
    endfunction

    function automatic logic op_writes_a(input logic [7:0] o);
        return o inside {[8'h01:8'h07]};
    endfunction

    // A writer issued in cycle t is still in flight during cycles t+1 .. t+DEPTH.
    function automatic logic is_blocked(input logic [7:0] r);
        int age;
        age = cyc - last_cyc[r];
        return (age >= 1) && (age <= DEPTH);
    endfunction

    function automatic void clear_model();
        for (int r = 0; r < 256; r++) last_cyc[r] = -1000;
        stall_cnt_model = 0;
    endfunction

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, OUT_VALID, 1'b0);
        checkOutput({tag, "_op"},    OUT_OP,    NOP_OP);
        checkOutput({tag, "_a"},     OUT_A,     16'h0000);
        checkOutput({tag, "_b"},     OUT_B,     16'h0000);
        checkOutput({tag, "_c"},     OUT_C,     16'h0000);
    endtask

    // Entered at posedge+1; presents one cycle of fetch input and checks both sides of the edge.
    task automatic applyStimulus(input logic valid, input logic [31:0] instr, output logic stalled);
        logic [7:0]  op, a, b, c;
        logic        exp_stall, issue;
        logic [15:0] eb, ec;
        {op, a, b, c} = instr;
        IN_VALID = valid;
        IN_INSTR = instr;
        #4;
        exp_stall = valid && ((op_reads_b(op) && is_blocked(b)) ||
                              (op_reads_c(op) && is_blocked(c)));
        issue = valid && !exp_stall;
        eb = op_reads_b(op) ? bank[b] : {8'h00, b};
        ec = op_reads_c(op) ? bank[c] : {8'h00, c};
        checkOutput("in_ready", IN_READY, !exp_stall);
        checkOutput("a_no", A_no, {8'h00, b});
        checkOutput("b_no", B_no, {8'h00, c});
        ready_seen = IN_READY;
        @(posedge CLK);
        if (issue && op_writes_a(op)) last_cyc[a] = cyc;
        if (exp_stall && stall_cnt_model != 65535) stall_cnt_model++;
        cyc++;
        #1;
        if (issue) begin
            checkOutput("out_valid", OUT_VALID, 1'b1);
            checkOutput("out_op", OUT_OP, op);
            checkOutput("out_a", OUT_A, {8'h00, a});
            checkOutput("out_b", OUT_B, eb);
            checkOutput("out_c", OUT_C, ec);
        end else begin
            checkIdle("bubble");
        end
`ifdef HAZARD_CNT_EN
        checkOutput("stall_cnt", STALL_CNT, stall_cnt_model);
`endif
        stalled = exp_stall;
    endtask

    // Entered at posedge+1; asserts reset mid-cycle and releases it just after the next edge.
    task automatic doReset();
        #4;
        RST = 1'b0;
        #1;
        clear_model();
        checkIdle("rst");
        checkOutput("rst_ready", IN_READY, 1'b1);
`ifdef HAZARD_CNT_EN
        checkOutput("rst_stall_cnt", STALL_CNT, 16'h0000);
`endif
        @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    initial begin
        logic        st;
        logic        held;
        logic        valid;
        logic [31:0] instr;
        int          n_stall;
        int          guard;

        assert_count = 0;
        fail_count   = 0;
        cyc          = 0;
        held         = 1'b0;
        valid        = 1'b0;
        instr        = 32'h0;
        for (int r = 0; r < 256; r++) bank[r] = 16'($urandom);
        bank[1] = 16'h0005;
        bank[2] = 16'h0007;
        clear_model();

        RST      = 1'b0;
        IN_VALID = 1'b0;
        IN_INSTR = 32'h0;
        @(posedge CLK);
        #1;
        checkIdle("reset");
        checkOutput("reset_ready", IN_READY, 1'b1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        applyStimulus(1'b0, 32'h0, st);

        $display("[TB] directed: AFC, ADD, hazard stall");
        applyStimulus(1'b1, 32'h06_03_2A_00, st);
        checkOutput("afc_out_b", OUT_B, 16'h002A);
        applyStimulus(1'b1, 32'h01_04_01_02, st);
        checkOutput("add_out_b", OUT_B, 16'h0005);
        checkOutput("add_out_c", OUT_C, 16'h0007);

        applyStimulus(1'b1, 32'h06_01_09_00, st);
        n_stall = 0;
        guard   = 0;
        do begin
            applyStimulus(1'b1, 32'h05_02_01_00, st);
            if (!ready_seen) n_stall++;
            guard++;
        end while (st && guard < 10);
        checkOutput("stall_len", n_stall, DEPTH);
        checkOutput("cop_issued", OUT_VALID, 1'b1);
`ifdef HAZARD_CNT_EN
        checkOutput("stall_cnt_3", STALL_CNT, 16'd3);
`endif

        $display("[TB] directed: spaced dependency, store after load");
        applyStimulus(1'b1, 32'h06_01_09_00, st);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 32'h00_00_00_00, st);
        applyStimulus(1'b1, 32'h05_02_01_00, st);
        checkOutput("spaced_ready", ready_seen, 1'b1);
        applyStimulus(1'b1, 32'h07_07_00_00, st);
        applyStimulus(1'b1, 32'h08_05_06_00, st);
        checkOutput("store_ready", ready_seen, 1'b1);

        $display("[TB] directed: reset during stall");
        applyStimulus(1'b1, 32'h06_01_09_00, st);
        applyStimulus(1'b1, 32'h05_02_01_00, st);
        checkOutput("pre_rst_stall", ready_seen, 1'b0);
        doReset();
        applyStimulus(1'b1, 32'h05_02_01_00, st);
        checkOutput("post_rst_ready", ready_seen, 1'b1);
        checkOutput("post_rst_issue", OUT_VALID, 1'b1);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            if (!held) begin
                valid = ($urandom_range(0, 3) != 0);
                instr = {8'($urandom_range(0, 10)), 8'($urandom_range(0, 3)),
                         8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
            end
            if (n == 200) doReset();
            applyStimulus(valid, instr, st);
            held = st;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
